// File: rtl/risc_pkg.sv
// risc_pkg: shared types and helpers for the 16-bit RISC core.
//   op_e       4-bit opcode encoding (10..15 are illegal)
//   flags_t    {c, n, z} condition flags
//   alu_res_t  single-cycle ALU result plus carry/borrow
//   alu_calc() single-cycle datapath used by the execute stage
// Build option: EXEC_MUL_EN (consumed by exec_unit) enables opcode MUL.
package risc_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_LDI = 4'd8,
    OP_MUL = 4'd9
  } op_e;

  typedef struct packed {
    logic c;
    logic n;
    logic z;
  } flags_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              c;
  } alu_res_t;

  function automatic alu_res_t alu_calc(op_e op, logic [DATA_W-1:0] a,
                                        logic [DATA_W-1:0] b, logic [7:0] imm);
    alu_res_t         r;
    logic [DATA_W:0]  sum;
    logic [3:0]       sh;
    logic [4:0]       idx;
    r   = '0;
    sum = '0;
    idx = '0;
    sh  = b[3:0];
    case (op)
      OP_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        r.result = sum[DATA_W-1:0];
        r.c      = sum[DATA_W];
      end
      OP_SUB: begin
        r.result = a - b;
        r.c      = (a < b);
      end
      OP_AND: r.result = a & b;
      OP_OR:  r.result = a | b;
      OP_XOR: r.result = a ^ b;
      OP_SHL: begin
        r.result = a << sh;
        // last bit shifted out of the top is a[16-sh]
        if (sh != 4'd0) begin
          idx = 5'd16 - {1'b0, sh};
          r.c = a[idx[3:0]];
        end
      end
      OP_SHR: begin
        r.result = a >> sh;
        if (sh != 4'd0) r.c = a[sh - 4'd1];
      end
      OP_LDI: r.result = {8'h00, imm};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_mul_seq.sv
// exec_mul_seq: 16-iteration shift-add multiplier (unsigned 16x16 -> 32).
//   clk, rst   clock, async active-high reset
//   start      load a/b and begin; only sampled when the caller is idle
//   a, b       operands
//   done       high for one cycle, during which product is valid
//   product    32-bit result
// Iterations 1..15 are registered; the 16th is folded into the combinational
// product so the result is available in the 16th cycle after start.
module exec_mul_seq
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [31:0]       product
);

  logic              active;
  logic [3:0]        cnt;
  logic [31:0]       acc;
  logic [31:0]       mcand;
  logic [DATA_W-1:0] mplier;
  logic [31:0]       acc_next;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign done     = active && (cnt == 4'd0);
  assign product  = acc_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= 4'd15;
      acc    <= '0;
      mcand  <= {16'h0000, a};
      mplier <= b;
    end else if (active) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (cnt == 4'd0) active <= 1'b0;
      else             cnt    <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute/writeback stage of the 16-bit RISC core.
//   clk, rst                          clock, async active-high reset
//   issue_valid/issue_ready           instruction handshake (ready only in IDLE)
//   issue_op/rd/rs1/rs2/imm           instruction fields
//   read_addr_1/2, read_data_1/2      GPR read ports (addresses are pass-through)
//   write_en/write_dest/write_data    registered one-cycle GPR write
//   flags                             {c, n, z}
//   busy                              high in EXEC or WB
//   illegal                           one-cycle pulse after an unknown opcode
// Build option: EXEC_MUL_EN adds the EXEC state and exec_mul_seq; without it
// opcode MUL is treated as illegal.
//
// state  | meaning
// IDLE   | ready; accepts instruction, single-cycle result computed at accept
// EXEC   | multiplier iterating (EXEC_MUL_EN only)
// WB     | write_en high for this one cycle
module exec_unit
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        issue_op,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic [7:0]        issue_imm,
  output logic [REG_AW-1:0] read_addr_1,
  output logic [REG_AW-1:0] read_addr_2,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  output logic              write_en,
  output logic [REG_AW-1:0] write_dest,
  output logic [DATA_W-1:0] write_data,
  output logic [2:0]        flags,
  output logic              busy,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef EXEC_MUL_EN
    S_EXEC = 2'd1,
`endif
    S_WB   = 2'd2
  } state_e;

  state_e   state;
  flags_t   flags_q;
  op_e      op_in;
  alu_res_t alu;
  logic     accept;
  logic     op_legal;

  assign op_in       = op_e'(issue_op);
  assign read_addr_1 = issue_rs1;
  assign read_addr_2 = issue_rs2;
  assign issue_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign accept      = issue_valid && (state == S_IDLE);
  assign flags       = flags_q;
  assign alu         = alu_calc(op_in, read_data_1, read_data_2, issue_imm);

  always_comb begin
    op_legal = 1'b0;
    case (op_in)
      OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SHL, OP_SHR, OP_LDI: op_legal = 1'b1;
`ifdef EXEC_MUL_EN
      OP_MUL:                         op_legal = 1'b1;
`endif
      default:                        op_legal = 1'b0;
    endcase
  end

`ifdef EXEC_MUL_EN
  logic        mul_start;
  logic        mul_done;
  logic [31:0] mul_product;

  assign mul_start = accept && (op_in == OP_MUL);

  exec_mul_seq u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (read_data_1),
    .b       (read_data_2),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      write_en   <= 1'b0;
      write_dest <= '0;
      write_data <= '0;
      flags_q    <= '0;
      illegal    <= 1'b0;
    end else begin
      write_en <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!op_legal) begin
              illegal <= 1'b1;
            end else if (op_in != OP_NOP) begin
              write_dest <= issue_rd;
`ifdef EXEC_MUL_EN
              if (op_in == OP_MUL) state <= S_EXEC;
              else
`endif
              begin
                state      <= S_WB;
                write_en   <= 1'b1;
                write_data <= alu.result;
                // LDI is the only legal non-NOP single-cycle op without flags
                if (op_in != OP_LDI)
                  flags_q <= '{c: alu.c, n: alu.result[DATA_W-1],
                               z: (alu.result == '0)};
              end
            end
          end
        end
`ifdef EXEC_MUL_EN
        S_EXEC: begin
          if (mul_done) begin
            state      <= S_WB;
            write_en   <= 1'b1;
            write_data <= mul_product[DATA_W-1:0];
            flags_q    <= '{c: |mul_product[31:16], n: mul_product[DATA_W-1],
                            z: (mul_product[DATA_W-1:0] == '0)};
          end
        end
`endif
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [3:0]  issue_op = 4'd0;
  logic [2:0]  issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
  logic [7:0]  issue_imm = '0;
  logic [2:0]  read_addr_1, read_addr_2;
  logic [15:0] read_data_1, read_data_2;
  logic        write_en;
  logic [2:0]  write_dest;
  logic [15:0] write_data;
  logic [2:0]  flags;
  logic        busy;
  logic        illegal;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  exec_unit dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_imm(issue_imm),
    .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .write_en(write_en), .write_dest(write_dest), .write_data(write_data),
    .flags(flags), .busy(busy), .illegal(illegal)
  );

  // GPR bank environment: all registers power up to 16'h0001
  logic [15:0] gpr [8];
  logic        gpr_init = 1'b1;
  assign read_data_1 = gpr[read_addr_1];
  assign read_data_2 = gpr[read_addr_2];
  always @(posedge clk) begin
    if (gpr_init) begin
      for (int k = 0; k < 8; k++) gpr[k] <= 16'h0001;
    end else if (write_en) begin
      gpr[write_dest] <= write_data;
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [7:0]  imm;
    int          we;
    logic [15:0] wd;
    logic [2:0]  fl;
    int          ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1,
                             logic [2:0] rs2, logic [7:0] imm, int we,
                             logic [15:0] wd, logic [2:0] fl, int ill, int lat);
    vec_t r;
    r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    r.we = we; r.wd = wd; r.fl = fl; r.ill = ill; r.lat = lat;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Issue one instruction and observe 24 cycles after the accept edge.
  task automatic do_op(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [7:0] imm,
                       output int we_cnt, output int lat, output logic [15:0] wd,
                       output logic [2:0] wdst, output logic [2:0] fl,
                       output int ill_cnt, output int rdy_low);
    int w;
    we_cnt = 0; lat = 0; wd = '0; wdst = '0; ill_cnt = 0; rdy_low = 0;
    @(negedge clk);
    w = 0;
    while (!issue_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!issue_ready) chk("ready wait timeout", 32'(issue_ready), 32'd1);
    issue_valid = 1'b1; issue_op = op; issue_rd = rd;
    issue_rs1 = rs1; issue_rs2 = rs2; issue_imm = imm;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      if (illegal) ill_cnt++;
      if (!issue_ready) rdy_low++;
      if (write_en) begin
        if (we_cnt == 0) begin
          lat = i; wd = write_data; wdst = write_dest;
        end
        we_cnt++;
      end
      @(posedge clk); #1;
    end
    fl = flags;
  endtask

  initial begin
    int we_cnt, lat, ill_cnt, rdy_low, cnt;
    logic [15:0] wd;
    logic [2:0]  wdst, fl;

    // op, rd, rs1, rs2, imm, we, wdata, flags{c,n,z}, illegal, latency
    vecs.push_back(v(4'd1, 3'd3, 3'd1, 3'd2, 8'h00, 1, 16'h0002, 3'b000, 0, 1));  // ADD
    vecs.push_back(v(4'd8, 3'd2, 3'd0, 3'd0, 8'h05, 1, 16'h0005, 3'b000, 0, 1));  // LDI
    vecs.push_back(v(4'd2, 3'd4, 3'd1, 3'd2, 8'h00, 1, 16'hFFFC, 3'b110, 0, 1));  // SUB borrow
    vecs.push_back(v(4'd8, 3'd1, 3'd0, 3'd0, 8'h03, 1, 16'h0003, 3'b110, 0, 1));  // LDI keeps flags
    vecs.push_back(v(4'd8, 3'd2, 3'd0, 3'd0, 8'h01, 1, 16'h0001, 3'b110, 0, 1));
    vecs.push_back(v(4'd7, 3'd7, 3'd1, 3'd2, 8'h00, 1, 16'h0001, 3'b100, 0, 1));  // SHR by 1
    vecs.push_back(v(4'd8, 3'd2, 3'd0, 3'd0, 8'h00, 1, 16'h0000, 3'b100, 0, 1));
    vecs.push_back(v(4'd7, 3'd7, 3'd1, 3'd2, 8'h00, 1, 16'h0003, 3'b000, 0, 1));  // SHR by 0
    vecs.push_back(v(4'd3, 3'd0, 3'd3, 3'd4, 8'h00, 1, 16'h0000, 3'b001, 0, 1));  // AND -> R0, zero
    vecs.push_back(v(4'd6, 3'd5, 3'd4, 3'd1, 8'h00, 1, 16'hFFE0, 3'b110, 0, 1));  // SHL by 3
    vecs.push_back(v(4'd5, 3'd6, 3'd5, 3'd4, 8'h00, 1, 16'h001C, 3'b000, 0, 1));  // XOR
    vecs.push_back(v(4'd4, 3'd6, 3'd3, 3'd1, 8'h00, 1, 16'h0003, 3'b000, 0, 1));  // OR
    vecs.push_back(v(4'd1, 3'd0, 3'd4, 3'd4, 8'h00, 1, 16'hFFF8, 3'b110, 0, 1));  // ADD carry
    vecs.push_back(v(4'd0, 3'd1, 3'd1, 3'd1, 8'h00, 0, 16'h0000, 3'b110, 0, 0));  // NOP
    vecs.push_back(v(4'hF, 3'd1, 3'd1, 3'd1, 8'h00, 0, 16'h0000, 3'b110, 1, 0));  // illegal
    vecs.push_back(v(4'd2, 3'd3, 3'd1, 3'd1, 8'h00, 1, 16'h0000, 3'b001, 0, 1));  // SUB zero
`ifdef EXEC_MUL_EN
    vecs.push_back(v(4'd8, 3'd1, 3'd0, 3'd0, 8'hC8, 1, 16'h00C8, 3'b001, 0, 1));
    vecs.push_back(v(4'd8, 3'd2, 3'd0, 3'd0, 8'hFA, 1, 16'h00FA, 3'b001, 0, 1));
    vecs.push_back(v(4'd9, 3'd5, 3'd1, 3'd2, 8'h00, 1, 16'hC350, 3'b010, 0, 17)); // MUL
    vecs.push_back(v(4'd9, 3'd6, 3'd5, 3'd5, 8'h00, 1, 16'hF900, 3'b110, 0, 17)); // MUL overflow
`else
    vecs.push_back(v(4'd9, 3'd5, 3'd1, 3'd2, 8'h00, 0, 16'h0000, 3'b001, 1, 0));  // MUL disabled
`endif

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst write_en", 32'(write_en), 32'd0);
    chk("rst write_dest", 32'(write_dest), 32'd0);
    chk("rst write_data", 32'(write_data), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst illegal", 32'(illegal), 32'd0);
    chk("rst issue_ready", 32'(issue_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    gpr_init = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
            we_cnt, lat, wd, wdst, fl, ill_cnt, rdy_low);
      chk($sformatf("v%0d write count", i), 32'(we_cnt), 32'(vecs[i].we));
      chk($sformatf("v%0d illegal cycles", i), 32'(ill_cnt), 32'(vecs[i].ill));
      chk($sformatf("v%0d flags", i), 32'(fl), 32'(vecs[i].fl));
      chk($sformatf("v%0d ready-low cycles", i), 32'(rdy_low), 32'(vecs[i].lat));
      if (vecs[i].we != 0) begin
        chk($sformatf("v%0d write_data", i), 32'(wd), 32'(vecs[i].wd));
        chk($sformatf("v%0d write_dest", i), 32'(wdst), 32'(vecs[i].rd));
        chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      end
    end

    // held issue_valid: second instruction waits through WB
    @(negedge clk);
    issue_valid = 1'b1; issue_op = 4'd8; issue_rd = 3'd3; issue_imm = 8'h11;
    @(posedge clk); #1;
    issue_rd = 3'd6; issue_imm = 8'h5A;
    chk("held first write_en", 32'(write_en), 32'd1);
    chk("held first data", 32'(write_data), 32'h0011);
    chk("held ready low", 32'(issue_ready), 32'd0);
    @(posedge clk); #1;
    chk("held gap write_en", 32'(write_en), 32'd0);
    chk("held gap ready", 32'(issue_ready), 32'd1);
    @(posedge clk); #1;
    issue_valid = 1'b0;
    chk("held second write_en", 32'(write_en), 32'd1);
    chk("held second data", 32'(write_data), 32'h005A);
    chk("held second dest", 32'(write_dest), 32'd6);

    // back-to-back NOPs accepted every cycle
    @(negedge clk);
    issue_valid = 1'b1; issue_op = 4'd0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (issue_ready && !write_en && !busy) cnt++;
    end
    issue_valid = 1'b0;
    chk("nop stream idle cycles", 32'(cnt), 32'd3);

`ifdef EXEC_MUL_EN
    // reset during the 8th EXEC cycle of a MUL
    @(negedge clk);
    issue_valid = 1'b1; issue_op = 4'd9; issue_rd = 3'd4; issue_rs1 = 3'd1; issue_rs2 = 3'd2;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid-mul busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid-mul rst write_en", 32'(write_en), 32'd0);
    chk("mid-mul rst flags", 32'(flags), 32'd0);
    chk("mid-mul rst ready", 32'(issue_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (write_en) cnt++;
    end
    chk("mid-mul no write", 32'(cnt), 32'd0);
    chk("mid-mul R4 intact", 32'(gpr[4]), 32'hFFFC);
`endif

    // reset during WB: the write must not land
    @(negedge clk);
    issue_valid = 1'b1; issue_op = 4'd1; issue_rd = 3'd7; issue_rs1 = 3'd3; issue_rs2 = 3'd3;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    chk("mid-wb write_en", 32'(write_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid-wb rst write_en", 32'(write_en), 32'd0);
    chk("mid-wb rst write_data", 32'(write_data), 32'd0);
    chk("mid-wb rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid-wb R7 intact", 32'(gpr[7]), 32'h0003);

    // normal operation after reset
    do_op(4'd1, 3'd3, 3'd1, 3'd2, 8'h00, we_cnt, lat, wd, wdst, fl, ill_cnt, rdy_low);
    chk("post-rst write count", 32'(we_cnt), 32'd1);
    chk("post-rst latency", 32'(lat), 32'd1);
`ifdef EXEC_MUL_EN
    chk("post-rst data", 32'(wd), 32'h01C2);
`else
    chk("post-rst data", 32'(wd), 32'h0003);
`endif
    chk("post-rst flags", 32'(fl), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Execute/writeback stage of the 16-bit RISC core. It sits directly downstream of the GPR read ports and directly upstream of the GPR write port. Per accepted instruction it:
- drives the two source register addresses;
- latches the returned operands;
- computes the result (single-cycle ALU op or multi-cycle shift-add multiply);
- issues one registered write back into the GPR bank and updates a 3-bit flags register.

## Interface
- DATA_W, 16, operand/result width
- REG_AW, 3, register address width (8 registers)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  instruction offered
- issue_ready  out  1  block can accept; high only in IDLE
- issue_op  in  4  opcode (op_e)
- issue_rd / issue_rs1 / issue_rs2  in  REG_AW each  destination, sources
- issue_imm  in  8  immediate for LDI
- read_addr_1 / read_addr_2  out  REG_AW  combinational copies of issue_rs1 / issue_rs2
- read_data_1 / read_data_2  in  DATA_W  combinational GPR read data
- write_en  out  1  GPR write strobe
- write_dest  out  REG_AW  GPR write address
- write_data  out  DATA_W  GPR write data
- flags  out  3  {C,N,Z}
- busy  out  1  high in EXEC or WB
- illegal  out  1  one-cycle pulse on an unknown opcode

## Operation
- **Opcodes:**
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 SHL, 7 SHR (logical): shift rs1 by rs2[3:0]
  - 8 LDI: rd = zero-extended imm
  - 9 MUL: low 16 bits of rs1*rs2
  - 10–15 illegal
- **FSM states:** IDLE, EXEC, WB.
- **Accept:** a transfer happens when issue_valid && issue_ready. On that edge, latch op, rd, imm, read_data_1 and read_data_2.
- **Transitions from IDLE on accept:**
  - Single-cycle op → WB.
  - MUL → EXEC.
  - NOP → stay IDLE.
  - Illegal opcode → stay IDLE; illegal=1 for the next cycle.
- **EXEC:** 16 shift-add iterations, then WB.
- **WB:** write_en=1 for exactly one cycle with the registered result, then IDLE.
- **Flag updates:**
  - Flags update in WB for ops 1–7 and 9. LDI, NOP and illegal opcodes leave flags unchanged.
  - Z = result==0; N = result[15].
  - C by op:
    - ADD: carry-out.
    - SUB: borrow (rs1<rs2 unsigned).
    - SHL/SHR: last bit shifted out; 0 when the shift amount is 0.
    - Logic ops: 0.
    - MUL: OR of product[31:16].
- **Width rules:** arithmetic is modulo 2^16. Writing any rd, including 0, is legal (no hardwired zero).
- **No read-after-write hazard:** issue_ready is low during WB, so the next instruction's operands are read after the GPR write lands.

## Timing
- **Reset values:**
  - write_en=0, write_dest=0, write_data=0, flags=0
  - busy=0, illegal=0
  - issue_ready=1 (state IDLE)
- **Single-cycle op:** accept at edge N → write_en high during cycle N+1 → GPR updated at edge N+2. Throughput is one op per 2 cycles.
- **MUL:** accept at edge N → write_en high during cycle N+17. issue_ready is low for 17 cycles.
- **NOP:** issue_ready stays high; back-to-back NOPs are accepted every cycle.
- **Held issue_valid:** if issue_valid is held while not ready, the instruction stays offered; it is accepted on the first ready cycle.
- **Reset mid-EXEC or mid-WB:** the operation is abandoned and no write occurs. Outputs take reset values immediately (asynchronously).

## Configuration
- **EXEC_MUL_EN defined:** the multiplier sub-module and the EXEC state are present; opcode 9 behaves as specified.
- **EXEC_MUL_EN undefined:** opcode 9 is illegal (illegal pulse, no write). The FSM has no EXEC state.

## Structure
- **Shared package risc_pkg:** op_e enum (4-bit), flags_t packed struct {c,n,z}, DATA_W/REG_AW constants.
- **Sub-module exec_mul_seq:** 16-cycle shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: done pulse, 32-bit product.
  - Instantiated only under EXEC_MUL_EN.

## Test plan
The GPR bank powers up with every register at 16'h0001.
- **ADD:** ADD rd=3, rs1=1, rs2=2 → write_en in cycle after accept, write_dest=3, write_data=16'h0002, flags=3'b000.
- **SUB with borrow:** LDI R2=8'h05; then SUB R4=R1-R2 → write_data=16'hFFFC, flags C=1, N=1, Z=0.
- **MUL:**
  - LDI R1=8'hC8; LDI R2=8'hFA; MUL R5 → write_data=16'hC350, C=0, write_en exactly 17 cycles after accept.
  - Then MUL R6=R5*R5 → 16'hF900, C=1, N=1.
- **SHR:** LDI R1=8'h03; SHR R7=R1>>R2 (R2=1) → write_data=16'h0001, C=1. With R2=0 the result is unchanged and C=0.
- **Reset mid-MUL:** assert rst during the 8th EXEC cycle → no write_en pulse, flags=0, issue_ready=1 after release. A following ADD completes normally.
- **Illegal opcode:** opcode 4'hF → illegal high exactly one cycle, no write, flags unchanged. With EXEC_MUL_EN undefined, opcode 9 gives the same response.
